// File: rtl/viterbi_ctrl_pkg.sv
// rtl/viterbi_ctrl_pkg.sv - shared types and constants for the Viterbi frame controller
// Contents:
//   state_t    : frame sequencer states
//   LFSR_TAPS  : Galois feedback polynomial for the injection LFSR
//   CNT_W      : width of the per-frame statistics counters
//   lfsr_step  : one right-shift Galois LFSR step
package viterbi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PAYLOAD,
        TAIL,
        DRAIN,
        DONE
    } state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam int          CNT_W     = 16;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/viterbi_lfsr32.sv
// rtl/viterbi_lfsr32.sv - 32-bit Galois LFSR with seed on reset and step enable
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset, loads SEED
//   en_i     : advance one step this cycle
//   state_o  : current LFSR state
module viterbi_lfsr32
    import viterbi_ctrl_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else if (en_i) begin
            state_q <= lfsr_step(state_q);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// rtl/viterbi_frame_ctrl.sv - frame sequencer for encoder, error injection and decoder checking
// Optional feature macro: ERR_BURST_EN (burst injection of 2^ERR_N symbols per trigger).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start_i, err_en_i  : frame start pulse, injection enable sampled at start
//   payload_i, payload_valid_i, payload_ready_o : payload bit handshake
//   enc_en_o, enc_d_o  : encoder enable and data bit
//   inj_mask_o         : XOR mask for the registered encoder symbol
//   dec_d_i            : decoder output bit, DEC_LAT cycles after the encoder bit
//   busy_o, done_o     : frame in progress, end-of-frame pulse
//   inj_ct_o, bit_err_ct_o : per-frame injected symbol and residual bit error counts
module viterbi_frame_ctrl
    import viterbi_ctrl_pkg::*;
#(
    parameter int          FRAME_LEN = 256,
    parameter int          TAIL_LEN  = 2,
    parameter int          DEC_LAT   = 8,
    parameter int          ERR_N     = 4,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             err_en_i,
    input  logic             payload_i,
    input  logic             payload_valid_i,
    output logic             payload_ready_o,
    output logic             enc_en_o,
    output logic             enc_d_o,
    output logic [1:0]       inj_mask_o,
    input  logic             dec_d_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] inj_ct_o,
    output logic [CNT_W-1:0] bit_err_ct_o
);

    localparam int TX_W = $clog2(FRAME_LEN + 1);
    localparam int TL_W = $clog2(TAIL_LEN + 2);

    state_t             state_q, state_d;
    logic [TX_W-1:0]    tx_cnt_q, rx_cnt_q;
    logic [TL_W-1:0]    tail_cnt_q;
    logic [DEC_LAT-1:0] ref_q, vld_q;
    logic [CNT_W-1:0]   inj_ct_q, bit_err_ct_q;
    logic [1:0]         inj_mask_q;
    logic               err_en_q;
    logic               hs, trig, mask_set, rx_chk;
    logic [31:0]        lfsr_state;
    logic               lfsr_unused;

    viterbi_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .en_i    (enc_en_o),
        .state_o (lfsr_state)
    );

    // Only the low ERR_N bits decide injection; the rest is intentionally unused.
    assign lfsr_unused = ^lfsr_state;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = PAYLOAD;
            PAYLOAD: if (hs && tx_cnt_q == TX_W'(FRAME_LEN - 1))
                         state_d = (TAIL_LEN == 0) ? DRAIN : TAIL;
            TAIL:    if (tail_cnt_q == TL_W'(TAIL_LEN - 1)) state_d = DRAIN;
            DRAIN:   if (rx_cnt_q == TX_W'(FRAME_LEN)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        payload_ready_o = 1'b0;
        enc_en_o        = 1'b0;
        enc_d_o         = 1'b0;
        busy_o          = 1'b1;
        done_o          = 1'b0;
        unique case (state_q)
            IDLE:    busy_o = 1'b0;
            PAYLOAD: begin
                payload_ready_o = 1'b1;
                enc_en_o        = payload_valid_i;
                enc_d_o         = payload_valid_i & payload_i;
            end
            TAIL:    enc_en_o = 1'b1;
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    assign hs     = payload_ready_o & payload_valid_i;
    assign trig   = err_en_q & (&lfsr_state[ERR_N-1:0]);
    assign rx_chk = vld_q[DEC_LAT-1];

`ifdef ERR_BURST_EN
    // Remaining symbols of the current burst after the triggering one.
    logic [ERR_N-1:0] burst_q, burst_d;

    always_comb begin
        mask_set = 1'b0;
        burst_d  = burst_q;
        if (state_q == IDLE || state_q == DONE) begin
            burst_d = '0;
        end else if (enc_en_o) begin
            if (burst_q != '0) begin
                mask_set = 1'b1;
                burst_d  = burst_q - ERR_N'(1);
            end else if (trig) begin
                mask_set = 1'b1;
                burst_d  = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    always_comb begin
        mask_set = enc_en_o & trig;
    end
`endif

    // Datapath: delay lines, frame counters, statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt_q     <= '0;
            rx_cnt_q     <= '0;
            tail_cnt_q   <= '0;
            ref_q        <= '0;
            vld_q        <= '0;
            inj_ct_q     <= '0;
            bit_err_ct_q <= '0;
            inj_mask_q   <= 2'b00;
            err_en_q     <= 1'b0;
        end else begin
            // Mask lands one cycle after the enc_en cycle, lined up with the registered encoder symbol.
            inj_mask_q <= mask_set ? 2'b11 : 2'b00;
            // Tail bits enter the flag line as invalid so they are never compared.
            ref_q      <= DEC_LAT'({ref_q, enc_d_o});
            vld_q      <= DEC_LAT'({vld_q, hs});
            tail_cnt_q <= (state_q == TAIL) ? tail_cnt_q + TL_W'(1) : '0;
            if (state_q == IDLE && start_i) begin
                err_en_q     <= err_en_i;
                tx_cnt_q     <= '0;
                rx_cnt_q     <= '0;
                inj_ct_q     <= '0;
                bit_err_ct_q <= '0;
            end else begin
                if (hs) tx_cnt_q <= tx_cnt_q + TX_W'(1);
                if (rx_chk) begin
                    rx_cnt_q <= rx_cnt_q + TX_W'(1);
                    if (dec_d_i != ref_q[DEC_LAT-1] && bit_err_ct_q != '1)
                        bit_err_ct_q <= bit_err_ct_q + CNT_W'(1);
                end
                if (mask_set && inj_ct_q != '1) inj_ct_q <= inj_ct_q + CNT_W'(1);
            end
        end
    end

    assign inj_mask_o   = inj_mask_q;
    assign inj_ct_o     = inj_ct_q;
    assign bit_err_ct_o = bit_err_ct_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb/tb_viterbi_frame_ctrl.sv - self-checking bench for viterbi_frame_ctrl
module tb_viterbi_frame_ctrl;

    localparam int          FL   = 16;
    localparam int          TL   = 2;
    localparam int          DL   = 8;
    localparam int          EN   = 1;
    localparam logic [31:0] SEED = 32'hACE1_0001;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i, err_en_i, payload_i, payload_valid_i;
    logic        payload_ready_o, enc_en_o, enc_d_o, dec_d_i, busy_o, done_o;
    logic [1:0]  inj_mask_o;
    logic [15:0] inj_ct_o, bit_err_ct_o;

    always #5 clk = ~clk;

    viterbi_frame_ctrl #(
        .FRAME_LEN(FL), .TAIL_LEN(TL), .DEC_LAT(DL), .ERR_N(EN), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .err_en_i(err_en_i),
        .payload_i(payload_i), .payload_valid_i(payload_valid_i),
        .payload_ready_o(payload_ready_o), .enc_en_o(enc_en_o), .enc_d_o(enc_d_o),
        .inj_mask_o(inj_mask_o), .dec_d_i(dec_d_i), .busy_o(busy_o), .done_o(done_o),
        .inj_ct_o(inj_ct_o), .bit_err_ct_o(bit_err_ct_o)
    );

    // Ideal encoder/decoder pair: decoded bit is the encoder bit DL cycles later,
    // optionally inverted to emulate a residual decoder error.
    logic [DL-1:0] dpipe   = '0;
    logic          flip_now = 1'b0;
    always @(posedge clk) dpipe <= {dpipe[DL-2:0], enc_d_o ^ flip_now};
    assign dec_d_i = dpipe[DL-1];

    int          nchk = 0;
    int          nfail = 0;
    logic [31:0] model_lfsr = SEED;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, payload_ready_o, 0);
        chk({tag, "_en"}, enc_en_o, 0);
        chk({tag, "_d"}, enc_d_o, 0);
        chk({tag, "_mask"}, inj_mask_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_inj"}, inj_ct_o, 0);
        chk({tag, "_berr"}, bit_err_ct_o, 0);
    endtask

    // Runs one frame from IDLE. gap: 0 = random valid, n = valid every n-th cycle.
    // flip: payload index the decoder inverts (out of range = none).
    // abort_at: assert rst once this many bits have been accepted (-1 = never).
    task automatic run_frame(input logic [15:0] data, input int gap, input bit een,
                             input int flip, input int abort_at, input bit poke_drain);
        int       sent, tail_done, exp_inj, exp_err, last_hs, burst_left;
        bit       done_seen, poked, exp_en, exp_rdy, exp_d, trig, m;
        logic [1:0]  exp_mask;
        logic [15:0] held_inj, held_err;
        sent = 0; tail_done = 0; exp_inj = 0; last_hs = 0; burst_left = 0;
        done_seen = 0; poked = 0; exp_mask = 2'b00;
        exp_err = (flip >= 0 && flip < FL) ? 1 : 0;

        start_i = 1'b1; err_en_i = een; payload_valid_i = 1'b0;
        #1 chk("start_from_idle_busy", busy_o, 0);
        @(negedge clk);
        start_i = 1'b0;

        for (int cyc = 0; cyc < 300; cyc++) begin
            flip_now = 1'b0;
            if (abort_at >= 0 && sent == abort_at) begin
                rst = 1'b1; payload_valid_i = 1'b0; start_i = 1'b0;
                @(negedge clk);
                #1 chk_idle_outputs("abort");
                rst = 1'b0;
                model_lfsr = SEED;
                @(negedge clk);
                return;
            end
            start_i = poke_drain && !poked && sent == FL && tail_done == TL;
            if (start_i) poked = 1;
            payload_valid_i = (sent < FL) && ((gap == 0) ? ($urandom_range(0, 1) == 1) : (cyc % gap == 0));
            payload_i = (sent < FL) ? data[sent] : 1'($urandom_range(0, 1));
            #1;
            if (cyc == 0) begin
                chk("inj_cleared_at_start", inj_ct_o, 0);
                chk("berr_cleared_at_start", bit_err_ct_o, 0);
            end
            chk("inj_mask", inj_mask_o, exp_mask);
            if (sent < FL) begin
                exp_rdy = 1; exp_en = payload_valid_i; exp_d = payload_valid_i & payload_i;
            end else if (tail_done < TL) begin
                exp_rdy = 0; exp_en = 1; exp_d = 0;
            end else begin
                exp_rdy = 0; exp_en = 0; exp_d = 0;
            end
            chk("payload_ready", payload_ready_o, exp_rdy);
            chk("enc_en", enc_en_o, exp_en);
            chk("enc_d", enc_d_o, exp_d);
            if (done_o) begin
                chk("done_tail_complete", (sent == FL && tail_done == TL), 1);
                chk("done_after_decode", (cyc >= last_hs + DL), 1);
                chk("inj_ct", inj_ct_o, exp_inj);
                chk("bit_err_ct", bit_err_ct_o, exp_err);
                chk("busy_in_done", busy_o, 1);
                held_inj = inj_ct_o; held_err = bit_err_ct_o;
                start_i = 1'b0; payload_valid_i = 1'b0;
                @(negedge clk);
                #1;
                chk("done_single_pulse", done_o, 0);
                chk("busy_after_done", busy_o, 0);
                chk("inj_held", inj_ct_o, held_inj);
                chk("berr_held", bit_err_ct_o, held_err);
                chk("mask_after_done", inj_mask_o, 0);
                @(negedge clk);
                return;
            end
            chk("busy_in_frame", busy_o, 1);
            exp_mask = 2'b00;
            if (exp_en) begin
                trig = een && (&model_lfsr[EN-1:0]);
`ifdef ERR_BURST_EN
                m = 0;
                if (burst_left > 0) begin m = 1; burst_left--; end
                else if (trig) begin m = 1; burst_left = (1 << EN) - 1; end
`else
                m = trig;
`endif
                if (m) begin exp_mask = 2'b11; exp_inj++; end
                model_lfsr = lfsr_next(model_lfsr);
                if (sent < FL) begin
                    flip_now = (sent == flip);
                    last_hs = cyc;
                    sent++;
                end else begin
                    tail_done++;
                end
            end
            @(negedge clk);
        end
        chk("frame_done_within_budget", done_seen, 1);
    endtask

    initial begin
        start_i = 1'b0; err_en_i = 1'b0; payload_i = 1'b0; payload_valid_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        run_frame(16'hA5C3, 1, 1'b0, -1, -1, 1'b0);
        run_frame(16'hA5C3, 3, 1'b0, -1, -1, 1'b1);
        run_frame(16'hA5C3, 1, 1'b1, -1, -1, 1'b0);
        run_frame(16'hA5C3, 1, 1'b0, 5, -1, 1'b0);
        run_frame(16'($urandom), 2, 1'b1, -1, 7, 1'b0);
        run_frame(16'h3C5A, 1, 1'b1, -1, -1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            run_frame(16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 24), -1, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
Frame-level sequencer for the encoder -> channel -> Viterbi decoder datapath.
- Accepts a payload bit stream and drives encoder enable/data.
- Appends TAIL_LEN zero flush bits.
- Schedules channel error injection from an internal LFSR, gated to a programmable window.
- Compares decoder output against the delayed payload and reports per-frame injected-error and residual-bit-error counts.
- Sits between the testbench/host stimulus and the encoder/decoder pair. Replaces the free-running error injection and counters in the tx/rx wrapper.

Parameters:
FRAME_LEN, 256, payload bits per frame (power of 2 not required, >= 1)
TAIL_LEN, 2, zero flush bits appended after payload (K-1)
DEC_LAT, 8, cycles from enc_en_o/enc_d_o to the matching dec_d_i bit
ERR_N, 4, inject when LFSR[ERR_N-1:0] == all-ones (rate 2^-ERR_N per symbol)
LFSR_SEED, 32'hACE1_0001, nonzero LFSR reset value

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start_i  input  1  pulse: begin a frame (ignored unless IDLE)
err_en_i  input  1  enables injection for the frame (sampled at start)
payload_i  input  1  payload bit
payload_valid_i  input  1  payload bit valid
payload_ready_o  output  1  controller accepts payload bit this cycle
enc_en_o  output  1  encoder enable
enc_d_o  output  1  encoder data bit
inj_mask_o  output  2  XOR mask applied to encoder output symbol
dec_d_i  input  1  decoder output bit
busy_o  output  1  frame in progress
done_o  output  1  one-cycle pulse at frame end
inj_ct_o  output  16  symbols corrupted this frame
bit_err_ct_o  output  16  decoded payload bits differing from sent

Behaviour:
- Reset (synchronous, active-high): all outputs 0; state IDLE; LFSR = LFSR_SEED; counters 0.
- IDLE:
  - start_i=1 -> PAYLOAD.
  - Clears inj_ct_o and bit_err_ct_o.
  - Latches err_en_i.
  - Clears tx_cnt and rx_cnt.
- PAYLOAD:
  - payload_ready_o=1.
  - Each payload_valid_i&&ready handshake: enc_en_o=1, enc_d_o=payload_i (combinational pass-through); tx_cnt++.
  - A bit is pushed into a DEC_LAT-deep reference delay line.
  - A valid gap deasserts enc_en_o; no bit is lost.
  - Last handshake (tx_cnt==FRAME_LEN-1) -> TAIL.
- TAIL:
  - payload_ready_o=0; enc_en_o=1; enc_d_o=0 for exactly TAIL_LEN cycles; then -> DRAIN.
  - TAIL_LEN=0 skips directly to DRAIN.
- DRAIN: waits until rx_cnt==FRAME_LEN, then -> DONE.
- DONE: done_o=1 for one cycle; counters hold; -> IDLE. busy_o=1 in every state except IDLE.
- Receive side:
  - A valid-flag delay line of DEC_LAT stages tracks enc_en_o for payload bits only; tail bits are flagged invalid.
  - When the delayed flag is 1: compare dec_d_i with the delayed reference bit; mismatch -> bit_err_ct_o++; rx_cnt++.
- Injection:
  - LFSR is 32-bit Galois, taps 0x8020_0003, advanced every cycle enc_en_o=1.
  - inj_mask_o=2'b11 on the cycle after an enc_en_o cycle (aligned to the registered encoder symbol) when err_en latched and LFSR[ERR_N-1:0]=='1; else 2'b00.
  - Each nonzero mask increments inj_ct_o.
  - Injection applies to payload and tail symbols.
- Counters saturate at 16'hFFFF; no wrap.
- start_i while busy is ignored.
- rst mid-frame aborts immediately: IDLE, no done_o, LFSR reseeded.

Optional Feature:
ERR_BURST_EN.
- Defined: an injection trigger starts a burst. inj_mask_o=2'b11 on the triggering symbol plus the next 2^ERR_N - 1 enc_en symbols. Triggers during a burst are ignored. A burst truncates at frame end.
- Undefined: independent per-symbol injection as above.

Decomposition:
- Package viterbi_ctrl_pkg:
  - state enum (IDLE, PAYLOAD, TAIL, DRAIN, DONE)
  - LFSR_TAPS constant
  - counter width constant CNT_W=16
- One sub-module, viterbi_lfsr32: seed/enable/step, 32-bit state output. The delay lines and FSM stay in the top.

Test Plan:
- FRAME_LEN=16, err_en_i=0, payload 16'hA5C3 streamed with ideal encoder/decoder model -> 18 enc_en_o cycles, last 2 with enc_d_o=0; done_o 1 pulse; inj_ct_o=0, bit_err_ct_o=0.
- Payload with valid gaps (valid every 3rd cycle) -> payload_ready_o handshakes exactly 16; enc_en_o only on handshakes; counts unchanged.
- err_en_i=1, ERR_N=1, seed default -> inj_ct_o equals golden LFSR model count; decoder bit errors match reference-model decode.
- Decoder model forced to invert bit 5 -> bit_err_ct_o=1 exactly.
- rst asserted mid-PAYLOAD (tx_cnt=7) -> next cycle all outputs 0, busy_o=0; a new start completes normally.
- start_i pulsed during DRAIN -> ignored; with ERR_BURST_EN, ERR_N=2 and a forced trigger -> 4 consecutive masked symbols.
